// File: rtl/fpu_addsub_ctrl.sv
// fpu_addsub_ctrl: sequences one fadd.s/fsub.s request from the core through the
// FP unit's A/B/OP operand streams and R result stream, stalling the core via BUSY.
// Optional build macro FPU_CTRL_TIMEOUT_EN adds an abort timer (TIMEOUT_CYCLES)
// that answers with a canonical qNaN plus RSP_ERR and drains one late result.
module fpu_addsub_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_OP,
    input  logic [31:0] REQ_A,
    input  logic [31:0] REQ_B,
    output logic        BUSY,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic [31:0] A_TDATA,
    output logic        A_TVALID,
    input  logic        A_TREADY,
    output logic [31:0] B_TDATA,
    output logic        B_TVALID,
    input  logic        B_TREADY,
    output logic [7:0]  OP_TDATA,
    output logic        OP_TVALID,
    input  logic        OP_TREADY,
    input  logic [31:0] R_TDATA,
    input  logic        R_TVALID,
    output logic        R_TREADY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        a_valid_q, a_valid_d;
    logic        b_valid_q, b_valid_d;
    logic        op_valid_q, op_valid_d;
    logic [31:0] a_data_q, a_data_d;
    logic [31:0] b_data_q, b_data_d;
    logic [7:0]  op_data_q, op_data_d;
    logic [31:0] rsp_data_q, rsp_data_d;

`ifdef FPU_CTRL_TIMEOUT_EN
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        rsp_err_q, rsp_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        drain_q, drain_d;
    logic        timeout_hit;

    // Counter reaches TIMEOUT_CYCLES on the coming edge.
    assign timeout_hit = (17'(cnt_q) + 17'd1) == 17'(TIMEOUT_CYCLES);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            op_valid_q <= 1'b0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            op_data_q  <= '0;
            rsp_data_q <= '0;
`ifdef FPU_CTRL_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            op_valid_q <= op_valid_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            op_data_q  <= op_data_d;
            rsp_data_q <= rsp_data_d;
`ifdef FPU_CTRL_TIMEOUT_EN
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
`endif
        end
    end

    // Next-state: issue operands, track each channel's handshake, collect result.
    always_comb begin
        state_d    = state_q;
        a_valid_d  = a_valid_q;
        b_valid_d  = b_valid_q;
        op_valid_d = op_valid_q;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;
        op_data_d  = op_data_q;
        rsp_data_d = rsp_data_q;
`ifdef FPU_CTRL_TIMEOUT_EN
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FPU_CTRL_TIMEOUT_EN
                if (drain_q && R_TVALID) begin
                    drain_d = 1'b0;
                end
`endif
                if (REQ_VALID) begin
                    a_data_d   = REQ_A;
                    b_data_d   = REQ_B;
                    op_data_d  = REQ_OP ? 8'h01 : 8'h00;
                    a_valid_d  = 1'b1;
                    b_valid_d  = 1'b1;
                    op_valid_d = 1'b1;
                    state_d    = ST_ISSUE;
`ifdef FPU_CTRL_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_ISSUE: begin
                a_valid_d  = a_valid_q  & ~A_TREADY;
                b_valid_d  = b_valid_q  & ~B_TREADY;
                op_valid_d = op_valid_q & ~OP_TREADY;
                if (!(a_valid_d || b_valid_d || op_valid_d)) begin
                    state_d = ST_WAIT;
                end
`ifdef FPU_CTRL_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
                if (timeout_hit) begin
                    a_valid_d  = 1'b0;
                    b_valid_d  = 1'b0;
                    op_valid_d = 1'b0;
                    rsp_data_d = QNAN;
                    rsp_err_d  = 1'b1;
                    drain_d    = 1'b1;
                    state_d    = ST_DONE;
                end
`endif
            end
            ST_WAIT: begin
`ifdef FPU_CTRL_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (R_TVALID) begin
                    rsp_data_d = R_TDATA;
`ifdef FPU_CTRL_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                    state_d    = ST_DONE;
                end
`ifdef FPU_CTRL_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_data_d = QNAN;
                    rsp_err_d  = 1'b1;
                    drain_d    = 1'b1;
                    state_d    = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state.
    assign REQ_READY = (state_q == ST_IDLE);
    assign BUSY      = ((state_q == ST_IDLE) && REQ_VALID) || (state_q == ST_ISSUE) ||
                       (state_q == ST_WAIT);
    assign RSP_VALID = (state_q == ST_DONE);
    assign RSP_DATA  = rsp_data_q;
    assign A_TDATA   = a_data_q;
    assign A_TVALID  = a_valid_q;
    assign B_TDATA   = b_data_q;
    assign B_TVALID  = b_valid_q;
    assign OP_TDATA  = op_data_q;
    assign OP_TVALID = op_valid_q;
`ifdef FPU_CTRL_TIMEOUT_EN
    assign RSP_ERR   = rsp_err_q;
    assign R_TREADY  = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && drain_q);
`else
    assign RSP_ERR   = 1'b0;
    assign R_TREADY  = (state_q == ST_WAIT);
`endif

endmodule
